// File: rtl/unit_fetch_ctx.sv
`default_nettype none
// ============================================================================
// Module   : unit_fetch_ctx
// Purpose  : Multi-context program counter and instruction fetch unit for the
//            multicycle processor. Holds one PC per process context (the BIOS
//            context being the kernel), fetches from synchronous instruction
//            memory, and handles BIOS-driven context switches, BIOS loading of
//            non-active PCs, and quantum-based preemption back to BIOS.
// Ports    : clk, reset (sync, active-high)
//            stall, pc_write, next_pc            - EXEC control / retirement
//            ctx_switch_req/target, ctx_switch_ack - explicit context switch
//            ctx_load, ctx_load_sel, ctx_load_pc - BIOS write of a non-active PC
//            preempt_en                          - enables the quantum counter
//            imem_addr, imem_rdata               - instruction memory
//            inst, inst_valid, pc, ret_addr      - to the datapath
//            active_ctx, in_bios, preempt, saved_ctx - context status
// Revision : 1.0 - initial release
// ============================================================================
module unit_fetch_ctx #(
    parameter int                  ADDR_W   = 32,
    parameter int                  INST_W   = 32,
    parameter int                  NUM_CTX  = 4,
    parameter int                  CTX_W    = 2,
    parameter logic [CTX_W-1:0]    BIOS_CTX = '0,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  QUANTUM  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              ctx_switch_req,
    input  logic [CTX_W-1:0]  ctx_switch_target,
    output logic              ctx_switch_ack,
    input  logic              ctx_load,
    input  logic [CTX_W-1:0]  ctx_load_sel,
    input  logic [ADDR_W-1:0] ctx_load_pc,
    input  logic              preempt_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [CTX_W-1:0]  active_ctx,
    output logic              in_bios,
    output logic              preempt,
    output logic [CTX_W-1:0]  saved_ctx
);

    // Counter only needs to reach QUANTUM-1: the retirement that would take
    // it to QUANTUM goes to SWITCH, which clears it.
    localparam int                 c_CNT_W   = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(QUANTUM - 1);
    localparam logic [CTX_W:0]     c_NUM_CTX  = (CTX_W + 1)'(NUM_CTX);

    localparam logic [1:0] c_ST_FETCH  = 2'd0;
    localparam logic [1:0] c_ST_EXEC   = 2'd1;
    localparam logic [1:0] c_ST_SWITCH = 2'd2;

    logic [ADDR_W-1:0]  r_pc_file [NUM_CTX];
    logic [1:0]         r_state;
    logic [CTX_W-1:0]   r_active_ctx;
    logic [CTX_W-1:0]   r_saved_ctx;
    logic [INST_W-1:0]  r_inst;
    logic               r_inst_valid;
    logic               r_ack;
    logic               r_preempt;
    logic               r_sw_is_preempt;
    logic [c_CNT_W-1:0] r_count;

    logic               w_in_bios;
    logic               w_retire;
    logic               w_preempt_hit;
    logic               w_explicit;
    logic               w_load_ok;
    logic               w_target_ok;

    assign w_in_bios     = (r_active_ctx == BIOS_CTX);
    assign w_retire      = (r_state == c_ST_EXEC) && !stall && pc_write;
    assign w_preempt_hit = w_retire && !w_in_bios && preempt_en && (r_count == c_CNT_LAST);
    // A request seen outside BIOS is simply not acted on; it remains pending
    // on the input until BIOS is active again.
    assign w_explicit    = ctx_switch_req && w_in_bios;
    assign w_load_ok     = ctx_load && w_in_bios && (ctx_load_sel != r_active_ctx) &&
                           ({1'b0, ctx_load_sel} < c_NUM_CTX);
    assign w_target_ok   = ({1'b0, ctx_switch_target} < c_NUM_CTX);

    // PC file: a retire writes the active entry, a BIOS load writes a
    // different entry, so both can apply in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CTX; i++) begin
            if (reset) begin
                r_pc_file[i] <= RESET_PC;
            end else if (w_retire && (CTX_W'(i) == r_active_ctx)) begin
                r_pc_file[i] <= next_pc;
            end else if (w_load_ok && (CTX_W'(i) == ctx_load_sel)) begin
                r_pc_file[i] <= ctx_load_pc;
            end
        end
    end

    // Control state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_FETCH;
            r_active_ctx    <= BIOS_CTX;
            r_saved_ctx     <= BIOS_CTX;
            r_inst          <= '0;
            r_inst_valid    <= 1'b0;
            r_ack           <= 1'b0;
            r_preempt       <= 1'b0;
            r_sw_is_preempt <= 1'b0;
            r_count         <= '0;
        end else begin
            // ack/preempt are high only for the SWITCH cycle that follows
            // the retiring edge.
            r_ack     <= 1'b0;
            r_preempt <= 1'b0;
            case (r_state)
                c_ST_FETCH: begin
                    r_inst       <= imem_rdata;
                    r_inst_valid <= 1'b1;
                    r_state      <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    if (w_retire) begin
                        r_inst_valid <= 1'b0;
                        if (w_preempt_hit) begin
                            r_state         <= c_ST_SWITCH;
                            r_sw_is_preempt <= 1'b1;
                            r_preempt       <= 1'b1;
                        end else if (w_explicit) begin
                            r_state         <= c_ST_SWITCH;
                            r_sw_is_preempt <= 1'b0;
                            r_ack           <= 1'b1;
                        end else begin
                            r_state <= c_ST_FETCH;
                            if (!w_in_bios && preempt_en) begin
                                r_count <= r_count + c_CNT_W'(1);
                            end
                        end
                    end
                end
                c_ST_SWITCH: begin
                    r_count <= '0;
                    r_state <= c_ST_FETCH;
                    if (r_sw_is_preempt) begin
                        r_saved_ctx  <= r_active_ctx;
                        r_active_ctx <= BIOS_CTX;
                    end else if (w_target_ok) begin
                        r_active_ctx <= ctx_switch_target;
                    end
                end
                default: begin
                    r_state <= c_ST_FETCH;
                end
            endcase
        end
    end

    assign pc             = r_pc_file[r_active_ctx];
    assign imem_addr      = pc;
    assign ret_addr       = pc + ADDR_W'(1);
    assign inst           = r_inst;
    assign inst_valid     = r_inst_valid;
    assign active_ctx     = r_active_ctx;
    assign in_bios        = w_in_bios;
    assign ctx_switch_ack = r_ack;
    assign preempt        = r_preempt;
    assign saved_ctx      = r_saved_ctx;

endmodule
`default_nettype wire

// File: tb/tb_unit_fetch_ctx.sv
`default_nettype none
// ============================================================================
// Module   : tb_unit_fetch_ctx
// Purpose  : Directed self-checking bench for unit_fetch_ctx (QUANTUM = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unit_fetch_ctx;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pc_write;
    logic [31:0] next_pc;
    logic        ctx_switch_req;
    logic [1:0]  ctx_switch_target;
    logic        ctx_switch_ack;
    logic        ctx_load;
    logic [1:0]  ctx_load_sel;
    logic [31:0] ctx_load_pc;
    logic        preempt_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] ret_addr;
    logic [1:0]  active_ctx;
    logic        in_bios;
    logic        preempt;
    logic [1:0]  saved_ctx;

    int checks   = 0;
    int failures = 0;

    unit_fetch_ctx #(
        .ADDR_W(32), .INST_W(32), .NUM_CTX(4), .CTX_W(2),
        .BIOS_CTX(2'd0), .RESET_PC(32'd0), .QUANTUM(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_write(pc_write),
        .next_pc(next_pc), .ctx_switch_req(ctx_switch_req),
        .ctx_switch_target(ctx_switch_target), .ctx_switch_ack(ctx_switch_ack),
        .ctx_load(ctx_load), .ctx_load_sel(ctx_load_sel), .ctx_load_pc(ctx_load_pc),
        .preempt_en(preempt_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .ret_addr(ret_addr),
        .active_ctx(active_ctx), .in_bios(in_bios), .preempt(preempt),
        .saved_ctx(saved_ctx)
    );

    always #5 clk = ~clk;

    // Advance one clock; observe 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (active_ctx !== 2'd0) begin failures++; $display("FAIL reset_ctx got=%0d exp=0", active_ctx); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (ctx_switch_ack !== 1'b0 || preempt !== 1'b0) begin failures++; $display("FAIL reset_pulses ack=%b preempt=%b exp=0,0", ctx_switch_ack, preempt); end
        checks++; if (saved_ctx !== 2'd0 || in_bios !== 1'b1) begin failures++; $display("FAIL reset_saved saved=%0d in_bios=%b exp=0,1", saved_ctx, in_bios); end
        reset = 1'b0;
    endtask

    task automatic test_sequential_fetch();
        // State is FETCH at pc 0.
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL seq_addr0 got=%h exp=0", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hDEAD_0000 + 32'(i);
            tick();  // now EXEC
            checks++; if (inst_valid !== 1'b1 || inst !== 32'hDEAD_0000 + 32'(i)) begin failures++; $display("FAIL seq_exec%0d valid=%b inst=%h exp=1,%h", i, inst_valid, inst, 32'hDEAD_0000 + 32'(i)); end
            if (i == 0) begin
                checks++; if (ret_addr !== 32'h1) begin failures++; $display("FAIL seq_ret_addr got=%h exp=1", ret_addr); end
            end
            pc_write = 1'b1;
            next_pc  = 32'(i + 1);
            tick();  // now FETCH
            pc_write = 1'b0;
            checks++; if (imem_addr !== 32'(i + 1) || inst_valid !== 1'b0) begin failures++; $display("FAIL seq_fetch%0d addr=%h valid=%b exp=%h,0", i, imem_addr, inst_valid, 32'(i + 1)); end
        end
    endtask

    task automatic test_ctx_load_switch();
        // BIOS, FETCH, pc 3.
        tick();  // EXEC
        ctx_load          = 1'b1;
        ctx_load_sel      = 2'd2;
        ctx_load_pc       = 32'h100;
        ctx_switch_req    = 1'b1;
        ctx_switch_target = 2'd2;
        pc_write          = 1'b1;
        next_pc           = 32'h4;
        tick();  // SWITCH
        ctx_load = 1'b0;
        pc_write = 1'b0;
        checks++; if (ctx_switch_ack !== 1'b1 || active_ctx !== 2'd0) begin failures++; $display("FAIL sw_ack ack=%b ctx=%0d exp=1,0", ctx_switch_ack, active_ctx); end
        tick();  // FETCH in ctx 2
        ctx_switch_req = 1'b0;
        checks++; if (ctx_switch_ack !== 1'b0) begin failures++; $display("FAIL sw_ack_pulse got=%b exp=0", ctx_switch_ack); end
        checks++; if (active_ctx !== 2'd2 || in_bios !== 1'b0) begin failures++; $display("FAIL sw_ctx ctx=%0d in_bios=%b exp=2,0", active_ctx, in_bios); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=100", imem_addr); end
        checks++; if (dut.r_pc_file[0] !== 32'h4) begin failures++; $display("FAIL sw_bios_pc got=%h exp=4", dut.r_pc_file[0]); end
    endtask

    // Ctx 2, quantum 4; the second retirement is held by a 5-cycle stall.
    task automatic test_preempt_stall();
        preempt_en = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();  // EXEC
            pc_write = 1'b1;
            next_pc  = 32'h100 + 32'(n);
            if (n == 2) begin
                stall = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    checks++; if (pc !== 32'h101 || inst_valid !== 1'b1) begin failures++; $display("FAIL stall_hold%0d pc=%h valid=%b exp=101,1", s, pc, inst_valid); end
                end
                stall = 1'b0;
            end
            tick();  // FETCH
            pc_write = 1'b0;
            checks++; if (preempt !== 1'b0 || active_ctx !== 2'd2 || pc !== 32'h100 + 32'(n)) begin failures++; $display("FAIL pre_retire%0d preempt=%b ctx=%0d pc=%h exp=0,2,%h", n, preempt, active_ctx, pc, 32'h100 + 32'(n)); end
        end
        tick();  // EXEC
        pc_write = 1'b1;
        next_pc  = 32'h104;
        tick();  // SWITCH
        pc_write = 1'b0;
        checks++; if (preempt !== 1'b1 || ctx_switch_ack !== 1'b0) begin failures++; $display("FAIL pre_pulse preempt=%b ack=%b exp=1,0", preempt, ctx_switch_ack); end
        tick();  // FETCH in BIOS
        checks++; if (preempt !== 1'b0 || saved_ctx !== 2'd2 || active_ctx !== 2'd0) begin failures++; $display("FAIL pre_done preempt=%b saved=%0d ctx=%0d exp=0,2,0", preempt, saved_ctx, active_ctx); end
        checks++; if (imem_addr !== 32'h4 || dut.r_pc_file[2] !== 32'h104) begin failures++; $display("FAIL pre_pcs addr=%h pc2=%h exp=4,104", imem_addr, dut.r_pc_file[2]); end
        preempt_en = 1'b0;
    endtask

    task automatic test_ignored_ops();
        // BIOS, FETCH, pc 4: load aimed at the active context is dropped.
        ctx_load     = 1'b1;
        ctx_load_sel = 2'd0;
        ctx_load_pc  = 32'h300;
        tick();  // EXEC
        ctx_load = 1'b0;
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL ign_self_load pc=%h exp=4", pc); end
        ctx_switch_req    = 1'b1;
        ctx_switch_target = 2'd2;
        pc_write          = 1'b1;
        next_pc           = 32'h5;
        tick();  // SWITCH
        pc_write = 1'b0;
        tick();  // FETCH in ctx 2
        ctx_switch_req = 1'b0;
        tick();  // EXEC in ctx 2
        ctx_switch_req    = 1'b1;
        ctx_switch_target = 2'd1;
        ctx_load          = 1'b1;
        ctx_load_sel      = 2'd1;
        ctx_load_pc       = 32'h200;
        pc_write          = 1'b1;
        next_pc           = 32'hFFFF_FFFF;
        tick();  // must be FETCH, not SWITCH
        pc_write = 1'b0;
        ctx_load = 1'b0;
        checks++; if (ctx_switch_ack !== 1'b0 || active_ctx !== 2'd2) begin failures++; $display("FAIL ign_user_req ack=%b ctx=%0d exp=0,2", ctx_switch_ack, active_ctx); end
        checks++; if (dut.r_pc_file[1] !== 32'h0) begin failures++; $display("FAIL ign_user_load pc1=%h exp=0", dut.r_pc_file[1]); end
        checks++; if (pc !== 32'hFFFF_FFFF || ret_addr !== 32'h0) begin failures++; $display("FAIL ign_wrap pc=%h ret=%h exp=ffffffff,0", pc, ret_addr); end
        tick();  // EXEC; still no ack
        ctx_switch_req = 1'b0;
        checks++; if (ctx_switch_ack !== 1'b0 || inst_valid !== 1'b1) begin failures++; $display("FAIL ign_no_ack ack=%b valid=%b exp=0,1", ctx_switch_ack, inst_valid); end
    endtask

    task automatic test_reset_in_switch();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // BIOS FETCH: load ctx 3, then switch to it.
        ctx_load     = 1'b1;
        ctx_load_sel = 2'd3;
        ctx_load_pc  = 32'h50;
        tick();  // EXEC
        ctx_load = 1'b0;
        checks++; if (dut.r_pc_file[3] !== 32'h50) begin failures++; $display("FAIL rs_load pc3=%h exp=50", dut.r_pc_file[3]); end
        ctx_switch_req    = 1'b1;
        ctx_switch_target = 2'd3;
        pc_write          = 1'b1;
        next_pc           = 32'h7;
        tick();  // SWITCH
        pc_write = 1'b0;
        checks++; if (ctx_switch_ack !== 1'b1) begin failures++; $display("FAIL rs_in_switch ack=%b exp=1", ctx_switch_ack); end
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        ctx_switch_req = 1'b0;
        checks++; if (active_ctx !== 2'd0 || ctx_switch_ack !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL rs_state ctx=%0d ack=%b addr=%h exp=0,0,0", active_ctx, ctx_switch_ack, imem_addr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.r_pc_file[i] !== 32'h0) begin failures++; $display("FAIL rs_pc%0d got=%h exp=0", i, dut.r_pc_file[i]); end
        end
        imem_rdata = 32'hCAFE_0001;
        tick();  // FETCH -> EXEC
        checks++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001) begin failures++; $display("FAIL rs_fetch valid=%b inst=%h exp=1,cafe0001", inst_valid, inst); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc_write = 1'b0; next_pc = '0;
        ctx_switch_req = 1'b0; ctx_switch_target = '0;
        ctx_load = 1'b0; ctx_load_sel = '0; ctx_load_pc = '0;
        preempt_en = 1'b0; imem_rdata = '0;
        test_reset();
        test_sequential_fetch();
        test_ctx_load_switch();
        test_preempt_stall();
        test_ignored_ops();
        test_reset_in_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/unit_fetch_ctx.md
Name: unit_fetch_ctx

Overview:
Parametrised multi-context program counter and instruction fetch unit for the multicycle processor. It holds one PC per process context, with context 0 acting as the BIOS/kernel context. It fetches from synchronous instruction memory and exposes the active instruction and return address to the datapath. It supports BIOS-driven context switches, BIOS loading of non-active PCs, and quantum-based preemption back to BIOS.

Parameters:
ADDR_W, 32, PC / instruction address width
INST_W, 32, instruction width
NUM_CTX, 4, number of PC contexts (2..16)
CTX_W, 2, context index width, at least clog2(NUM_CTX)
BIOS_CTX, 0, index of the BIOS context
RESET_PC, 0, value loaded into every PC on reset
QUANTUM, 64, instructions retired in a user context before preemption (≥1)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
stall  in  1  freezes EXEC (no retirement, no state change)
pc_write  in  1  retire current instruction; load next_pc
next_pc  in  ADDR_W  next PC computed by branch/jump logic
ctx_switch_req  in  1  level request; held until ctx_switch_ack
ctx_switch_target  in  CTX_W  context to switch to
ctx_switch_ack  out  1  one-cycle pulse when switch completes
ctx_load  in  1  write a non-active context PC
ctx_load_sel  in  CTX_W  context to write
ctx_load_pc  in  ADDR_W  value to write
preempt_en  in  1  enables the quantum counter
imem_addr  out  ADDR_W  instruction memory address; read data returns next cycle
imem_rdata  in  INST_W  instruction memory data
inst  out  INST_W  registered current instruction
inst_valid  out  1  inst is valid (EXEC state)
pc  out  ADDR_W  active context PC
ret_addr  out  ADDR_W  pc + 1, combinational, wraps modulo 2^ADDR_W
active_ctx  out  CTX_W  active context
in_bios  out  1  active_ctx == BIOS_CTX
preempt  out  1  one-cycle pulse in the SWITCH cycle caused by preemption
saved_ctx  out  CTX_W  context interrupted by the last preemption

Behaviour:
- Reset:
  - All PCs = RESET_PC; active_ctx = BIOS_CTX; state = FETCH.
  - inst = 0; inst_valid = 0; ctx_switch_ack = 0; preempt = 0; saved_ctx = BIOS_CTX; quantum count = 0.
  - Reset during any state, including SWITCH, discards the operation in progress.
- imem_addr = pc_file[active_ctx] in all states.
- FETCH (one cycle):
  - inst <= imem_rdata; inst_valid <= 1; go to EXEC.
  - stall is ignored in FETCH.
- EXEC:
  - stall = 1: hold everything.
  - stall = 0 and pc_write = 1 (retire): pc_file[active] <= next_pc; inst_valid <= 0.
  - On retire, go to SWITCH if a switch is pending, else go to FETCH.
  - pc_write = 0: remain in EXEC.
- Pending switch is one of:
  - Explicit: ctx_switch_req = 1 while in_bios.
  - Preemption: retire in a non-BIOS context with preempt_en = 1 and count == QUANTUM-1.
- ctx_switch_req outside BIOS is ignored; no ack is generated and the request stays pending until BIOS is active.
- Switches happen only at instruction boundaries. Minimum latency from retire to ack is 1 cycle (SWITCH).
- SWITCH (one cycle), explicit:
  - active_ctx <= ctx_switch_target, or unchanged if target ≥ NUM_CTX.
  - ctx_switch_ack = 1.
- SWITCH (one cycle), preemption:
  - saved_ctx <= active_ctx; active_ctx <= BIOS_CTX; preempt = 1.
  - No ctx_switch_ack.
- Every SWITCH: count <= 0; go to FETCH.
- A switch to the already-active context still takes the SWITCH cycle and acks.
- Quantum counter:
  - Increments on each user-context retirement with preempt_en = 1.
  - Holds when preempt_en = 0 or when in BIOS.
  - Clears on SWITCH and on reset.
- ctx_load:
  - Honoured only while in_bios and ctx_load_sel != active_ctx and ctx_load_sel < NUM_CTX; otherwise ignored.
  - May coincide with a retire or a SWITCH; both updates apply.
  - A load to the context being switched to is visible in the following FETCH.
- Each instruction takes at least 2 cycles (FETCH + EXEC); a context switch adds 1 cycle.

Test Plan:
- Reset, then retire 3 instructions with next_pc = pc+1 → imem_addr 0,1,2,3; inst_valid low in each FETCH; ret_addr = 1 during first EXEC.
- In BIOS: ctx_load sel=2 pc=0x100; ctx_switch_req target=2 → retire, SWITCH with ack pulse, active_ctx=2, imem_addr=0x100 next cycle.
- QUANTUM=4, ctx 2, preempt_en=1 → 4th retirement gives SWITCH with preempt=1, saved_ctx=2, active_ctx=0; pc_file[2] holds the 4th next_pc.
- Stall held 5 cycles in EXEC with pc_write=1 → no PC change, no count increment; releasing stall retires exactly once.
- ctx_switch_req in user context with preempt_en=0 → no ack; ctx_load targeting the active context or issued from user context → ignored; PC 0xFFFFFFFF gives ret_addr 0.
- Assert reset in the SWITCH cycle → active_ctx=0, all PCs=RESET_PC, ack=0, state FETCH.
